// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: the received word, its valid/ready pair and the error pulses.
// The receiver drives the master modport and the consumer drives the slave modport.
interface uart_rx_if #(
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] rx_data;
  logic                   rx_data_valid;
  logic                   rx_data_ready;
  logic                   frame_error;
  logic                   overrun;

  modport master (
    output rx_data,
    output rx_data_valid,
    output frame_error,
    output overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  frame_error,
    input  overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1-style framing with a configurable word length and a one-word output register.
// A frame is still sampled while the consumer stalls; in that case the new word is dropped and flagged.
module uart_rx #(
  parameter int CLKRATE     = 100000000,
  parameter int BAUD        = 115200,
  parameter int WORD_LENGTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      UART_RX,
  uart_rx_if.master rx_if
);

  localparam int CLKS_PER_BIT = CLKRATE / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [WORD_LENGTH-1:0] r_shift;
  logic [WORD_LENGTH-1:0] r_data;
  logic                   r_valid;
  logic                   r_frame_error;
  logic                   r_overrun;

  logic w_rxs;
  logic w_cnt_clr;
  logic w_cnt_run;
  logic w_idx_clr;
  logic w_sample_bit;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_load;
  logic w_drop;

  assign w_rxs = r_sync2;

  // Two-flop synchronizer; both flops reset to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_sync2 <= r_sync1;
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_run    = 1'b0;
    w_idx_clr    = 1'b0;
    w_sample_bit = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_cnt_clr    = 1'b1;
          w_next_state = S_START;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_START: begin
        w_cnt_run = 1'b1;
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr = 1'b1;
          // A line that is high again at mid start bit was only a glitch
          if (!w_rxs) begin
            w_idx_clr    = 1'b1;
            w_next_state = S_DATA;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_START;
        end
      end
      S_DATA: begin
        w_cnt_run = 1'b1;
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr    = 1'b1;
          w_sample_bit = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_next_state = S_STOP;
          end else begin
            w_next_state = S_DATA;
          end
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_STOP: begin
        w_cnt_run = 1'b1;
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr = 1'b1;
          if (w_rxs) begin
            w_stop_ok    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_next_state = S_WAIT_IDLE;
          end
        end else begin
          w_next_state = S_STOP;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) parks here so only one frame error is raised
        if (w_rxs) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output register is free when empty or being consumed on this same edge
  always_comb begin
    w_load = 1'b0;
    w_drop = 1'b0;
    if (w_stop_ok) begin
      if (!r_valid || rx_if.rx_data_ready) begin
        w_load = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end else begin
      w_load = 1'b0;
      w_drop = 1'b0;
    end
  end

  // Bit-period counter, data bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_run) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_sample_bit) begin
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_idx <= r_idx;
      end
      if (w_sample_bit) begin
        r_shift <= {w_rxs, r_shift[WORD_LENGTH-1:1]};
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  // Registered word, valid flag and single-cycle error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_error <= w_stop_bad;
      r_overrun     <= w_drop;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_if.rx_data_ready) begin
        r_data  <= r_data;
        r_valid <= 1'b0;
      end else begin
        r_data  <= r_data;
        r_valid <= r_valid;
      end
    end
  end

  assign rx_if.rx_data       = r_data;
  assign rx_if.rx_data_valid = r_valid;
  assign rx_if.frame_error   = r_frame_error;
  assign rx_if.overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus side queues expected words and error events,
// a negedge monitor pops and compares them as the receiver presents them.
module tb_uart_rx;
  localparam int CPB = 10;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;

  uart_rx_if #(.WORD_LENGTH(8)) u_if ();

  uart_rx #(
    .CLKRATE    (1000000),
    .BAUD       (100000),
    .WORD_LENGTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .UART_RX(line),
    .rx_if  (u_if.master)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] wq[$];
  int         eq[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit stop);
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line = ((d >> i) & 8'd1) != 8'd0;
      tick(CPB);
    end
    line = stop;
    tick(CPB);
    line = 1'b1;
  endtask

  // Expected outcomes: good stop -> word delivered (or overrun when the consumer is full), bad stop -> frame error
  task automatic frame(input logic [7:0] d, input bit stop, input bit full);
    if (!stop) eq.push_back(0);
    else if (full) eq.push_back(1);
    else wq.push_back(d);
    send(d, stop);
  endtask

  // Monitor: consumes words at handshake, error pulses when seen, and checks hold stability
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) check("hold_stable", u_if.rx_data, prev_data);
      if (u_if.rx_data_valid && u_if.rx_data_ready) begin
        if (wq.size() == 0) check("unexpected_word", u_if.rx_data, -1);
        else check("word", u_if.rx_data, wq.pop_front());
      end
      if (u_if.frame_error) begin
        if (eq.size() == 0) check("unexpected_frame_error", 1, 0);
        else check("err_kind_ferr", 0, eq.pop_front());
      end
      if (u_if.overrun) begin
        if (eq.size() == 0) check("unexpected_overrun", 1, 0);
        else check("err_kind_ovr", 1, eq.pop_front());
      end
      prev_hold = u_if.rx_data_valid && !u_if.rx_data_ready;
      prev_data = u_if.rx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    u_if.rx_data_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_data", u_if.rx_data, 0);
    check("rst_valid", u_if.rx_data_valid, 0);
    check("rst_ferr", u_if.frame_error, 0);
    check("rst_ovr", u_if.overrun, 0);

    // Single word with consumer ready
    frame(8'hA5, 1'b1, 1'b0);
    tick(2 * CPB);

    // Back-pressure: first word held, second dropped with overrun
    u_if.rx_data_ready = 1'b0;
    frame(8'h3C, 1'b1, 1'b0);
    tick(CPB);
    frame(8'h81, 1'b1, 1'b1);
    tick(2 * CPB);
    check("held_valid", u_if.rx_data_valid, 1);
    check("held_data", u_if.rx_data, 8'h3C);
    u_if.rx_data_ready = 1'b1;
    tick(2);
    check("valid_cleared", u_if.rx_data_valid, 0);

    // Bad stop bit, then a good frame
    frame(8'h55, 1'b0, 1'b0);
    tick(2 * CPB);
    check("ferr_no_valid", u_if.rx_data_valid, 0);
    frame(8'h12, 1'b1, 1'b0);
    tick(2 * CPB);

    // Short low glitch on an idle line, then a frame 8 cycles later
    line = 1'b0;
    tick(3);
    line = 1'b1;
    tick(8);
    check("glitch_no_valid", u_if.rx_data_valid, 0);
    frame(8'h6D, 1'b1, 1'b0);
    tick(2 * CPB);

    // Reset pulse during bit 4 of 0x5A (bit 4 high), line left idle afterwards
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      line = ((8'h5A >> i) & 8'd1) != 8'd0;
      tick(CPB);
    end
    line = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(15 * CPB);
    frame(8'hF0, 1'b1, 1'b0);
    tick(2 * CPB);

    // Back-to-back frames with no idle gap
    frame(8'h00, 1'b1, 1'b0);
    frame(8'hFF, 1'b1, 1'b0);
    tick(2 * CPB);

    // Break: line held low well past the stop bit gives a single frame error
    eq.push_back(0);
    line = 1'b0;
    tick(30 * CPB);
    line = 1'b1;
    tick(2 * CPB);

    // Randomized frames with random bad stops and gaps
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      bit         stop;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      frame(d, stop, 1'b0);
      tick($urandom_range(0, 3) * CPB);
    end

    for (int c = 0; c < 400 && (wq.size() != 0 || eq.size() != 0); c++) tick(1);
    check("words_drained", wq.size(), 0);
    check("errors_drained", eq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
